weight_pingpong_buffer: RTL and testbench

- Double-buffered int8 weight store that serves the weight read port of the matvec engine: it takes the engine's weight_addr and returns weight_data in the same cycle.
- The loader side fills the shadow bank from a 32-bit valid/ready word stream while the matvec reads the active bank.
- A swap handshake promotes the fully loaded shadow bank to active, so the next layer's weights stream in during the current layer's compute.

---
 rtl/weight_pingpong_buffer.sv | 114 +++++++++++
 tb/tb_weight_pingpong_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered int8 weight store: the loader fills the shadow bank from a
// 32-bit word stream while the matvec reads the active bank combinationally.
module weight_pingpong_buffer #(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  output logic                 load_done,
  output logic                 shadow_full,
  input  logic                 swap,
  output logic                 swap_ack,
  output logic                 swap_ignored,
  output logic                 active_valid,
  input  logic [AW-1:0]        weight_addr,
  output logic signed [7:0]    weight_data
);

  localparam int WORDS = DEPTH / 4;
  localparam int WW    = AW - 2;
  localparam logic [WW-1:0] LAST_W  = WW'(WORDS - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

  typedef enum logic {ST_LOAD, ST_FULL} state_t;

  state_t        r_state;
  logic [WW-1:0] r_wptr;
  logic          r_bank_sel;
  logic          r_s_ready;
  logic          r_load_done;
  logic          r_shadow_full;
  logic          r_swap_ack;
  logic          r_swap_ignored;
  logic          r_active_valid;

  logic [7:0]    r_mem [2][DEPTH];

  logic          w_shadow;
  logic          w_accept;
  logic          w_rd_ok;

  assign w_shadow = ~r_bank_sel;
  assign w_accept = (r_state == ST_LOAD) && s_valid && r_s_ready && !rst;
  assign w_rd_ok  = r_active_valid && ({1'b0, weight_addr} < DEPTH_L);

  // Storage is never reset; only the shadow bank is ever written.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_mem[w_shadow][{r_wptr, 2'(k)}] <= s_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_LOAD;
      r_wptr         <= '0;
      r_bank_sel     <= 1'b0;
      r_s_ready      <= 1'b0;
      r_load_done    <= 1'b0;
      r_shadow_full  <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_swap_ignored <= 1'b0;
      r_active_valid <= 1'b0;
    end else begin
      r_load_done    <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_swap_ignored <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          r_s_ready      <= 1'b1;
          r_swap_ignored <= swap;
          if (s_valid && r_s_ready) begin
            if (r_wptr == LAST_W) begin
              r_wptr        <= '0;
              r_load_done   <= 1'b1;
              r_shadow_full <= 1'b1;
              r_s_ready     <= 1'b0;
              r_state       <= ST_FULL;
            end else begin
              r_wptr <= r_wptr + 1'b1;
            end
          end
        end
        ST_FULL: begin
          r_s_ready <= 1'b0;
          if (swap) begin
            r_bank_sel     <= ~r_bank_sel;
            r_active_valid <= 1'b1;
            r_shadow_full  <= 1'b0;
            r_swap_ack     <= 1'b1;
            r_s_ready      <= 1'b1;
            r_wptr         <= '0;
            r_state        <= ST_LOAD;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign s_ready      = r_s_ready;
  assign load_done    = r_load_done;
  assign shadow_full  = r_shadow_full;
  assign swap_ack     = r_swap_ack;
  assign swap_ignored = r_swap_ignored;
  assign active_valid = r_active_valid;
  assign weight_data  = w_rd_ok ? r_mem[r_bank_sel][weight_addr] : '0;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Self-checking bench for weight_pingpong_buffer (DEPTH=16): directed table,
// hand-written corner sequences and random traffic against a reference model.
module tb_weight_pingpong_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                 clk = 1'b0;
  logic                 rst, s_valid, s_ready, load_done, shadow_full;
  logic                 swap, swap_ack, swap_ignored, active_valid;
  logic [31:0]          s_data;
  logic [AW-1:0]        weight_addr;
  logic signed [7:0]    weight_data;
  logic [7:0]           w_wd_u;

  always #5 clk = ~clk;
  assign w_wd_u = weight_data;

  weight_pingpong_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .load_done(load_done), .shadow_full(shadow_full), .swap(swap),
    .swap_ack(swap_ack), .swap_ignored(swap_ignored), .active_valid(active_valid),
    .weight_addr(weight_addr), .weight_data(weight_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two byte arrays, which one is served, and how many words
  // of the current fill have landed.
  logic [7:0] m_mem [2][DEPTH];
  int         m_sel, m_words;
  bit         m_ready, m_ld, m_full, m_ack, m_ign, m_av;

  function automatic logic [7:0] model_read(input logic [AW-1:0] a);
    return m_av ? m_mem[m_sel][a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_ld = 0; m_ack = 0; m_ign = 0;
    if (rst) begin
      m_ready = 0; m_full = 0; m_av = 0; m_sel = 0; m_words = 0;
    end else if (!m_full) begin
      m_ign = swap;
      if (s_valid && m_ready) begin
        for (int k = 0; k < 4; k++) m_mem[1 - m_sel][4*m_words + k] = s_data[8*k +: 8];
        m_words++;
        if (m_words == DEPTH/4) begin
          m_words = 0; m_ld = 1; m_full = 1; m_ready = 0;
        end
      end else begin
        m_ready = 1;
      end
    end else if (swap) begin
      m_sel = 1 - m_sel; m_av = 1; m_full = 0; m_ack = 1; m_ready = 1; m_words = 0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic sw, input logic [AW-1:0] a);
    rst = r; s_valid = v; s_data = d; swap = sw; weight_addr = a;
    @(posedge clk);
    model_edge();
    #1;
    chk("s_ready",      s_ready,      m_ready);
    chk("load_done",    load_done,    m_ld);
    chk("shadow_full",  shadow_full,  m_full);
    chk("swap_ack",     swap_ack,     m_ack);
    chk("swap_ignored", swap_ignored, m_ign);
    chk("active_valid", active_valid, m_av);
    chk("weight_data",  w_wd_u,       model_read(a));
  endtask

  typedef struct {
    logic r, v; logic [31:0] d; logic sw; logic [3:0] a;
    logic e_rdy, e_ld, e_full, e_ack, e_ign, e_av; logic [7:0] e_wd;
  } vec_t;
  vec_t tbl[11];

  initial begin
    rst = 1; s_valid = 0; s_data = '0; swap = 0; weight_addr = '0;
    //         r  v  data          sw a    rdy ld full ack ign av wd
    tbl[0]  = '{1, 0, 32'h0,        0, 0,  0,  0, 0,   0,  0,  0, 8'h00};
    tbl[1]  = '{0, 0, 32'h0,        0, 0,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[2]  = '{0, 1, 32'h03020100, 0, 1,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[3]  = '{0, 0, 32'h0,        0, 2,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[4]  = '{0, 1, 32'h07060504, 0, 3,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[5]  = '{0, 1, 32'h0B0A0908, 0, 4,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[6]  = '{0, 0, 32'h0,        0, 5,  1,  0, 0,   0,  0,  0, 8'h00};
    tbl[7]  = '{0, 1, 32'h0F0E0D0C, 0, 6,  0,  1, 1,   0,  0,  0, 8'h00};
    tbl[8]  = '{0, 1, 32'hDEADBEEF, 0, 7,  0,  0, 1,   0,  0,  0, 8'h00};
    tbl[9]  = '{0, 0, 32'h0,        1, 5,  1,  0, 0,   1,  0,  1, 8'h05};
    tbl[10] = '{0, 0, 32'h0,        0, 15, 1,  0, 0,   0,  0,  1, 8'h0F};

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].sw, tbl[i].a);
      chk("tbl_rdy",  s_ready,      tbl[i].e_rdy);
      chk("tbl_ld",   load_done,    tbl[i].e_ld);
      chk("tbl_full", shadow_full,  tbl[i].e_full);
      chk("tbl_ack",  swap_ack,     tbl[i].e_ack);
      chk("tbl_ign",  swap_ignored, tbl[i].e_ign);
      chk("tbl_av",   active_valid, tbl[i].e_av);
      chk("tbl_wd",   w_wd_u,       tbl[i].e_wd);
    end
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 0, 0, 0, AW'(k));
      chk("seq_ramp", w_wd_u, 8'(k));
    end

    // Fill shadow with 0xFF while the ramp stays visible, then swap.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'hFFFFFFFF, 0, 4'd5);
      chk("fill_keeps_active", w_wd_u, 8'h05);
    end
    step(0, 0, 0, 1, 4'd5);
    chk("swap_neg1_ack", swap_ack, 1'b1);
    chk("swap_neg1",     w_wd_u,   8'hFF);

    // Swap mid-fill is ignored; final word coincides with a swap request.
    step(0, 1, 32'h13121110, 0, 4'd5);
    step(0, 1, 32'h17161514, 0, 4'd5);
    step(0, 0, 0, 1, 4'd5);
    chk("midfill_ign",  swap_ignored, 1'b1);
    chk("midfill_bank", w_wd_u,       8'hFF);
    step(0, 1, 32'h1B1A1918, 0, 4'd5);
    chk("ign_one_cycle", swap_ignored, 1'b0);
    step(0, 1, 32'h1F1E1D1C, 1, 4'd5);
    chk("final_swap_ld",  load_done,    1'b1);
    chk("final_swap_ign", swap_ignored, 1'b1);
    chk("final_full",     shadow_full,  1'b1);
    step(0, 0, 0, 1, 4'd8);
    chk("final_swap_ack", swap_ack, 1'b1);
    chk("final_word2",    w_wd_u,   8'h18);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, AW'(k));

    // Reset mid-fill drops the active bank until a new fill+swap completes.
    step(0, 1, 32'hA3A2A1A0, 0, 4'd1);
    step(0, 1, 32'hA7A6A5A4, 0, 4'd1);
    step(1, 0, 0, 0, 4'd1);
    chk("rst_av", active_valid, 1'b0);
    chk("rst_wd", w_wd_u,       8'h00);
    step(0, 0, 0, 0, 4'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h40404040 + 32'(i) * 32'h01010101, 0, 4'd1);
    chk("rst_refill_wd", w_wd_u, 8'h00);
    step(0, 1, 32'h99999999, 0, 4'd1);
    step(0, 0, 0, 1, 4'd1);
    chk("refill_word0", w_wd_u, 8'h40);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, AW'(k));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) == 0), $urandom_range(1), $urandom,
           ($urandom_range(5) == 0), AW'($urandom_range(DEPTH - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
